instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage feeding the single-cycle core's decode/execute path. Holds the fetch PC, issues in-order word requests to a variable-latency instruction memory over a valid/ready request channel, buffers returned instructions in a small FIFO, and presents {instruction, PC} pairs to the core through a valid/ready handshake. Taken branches and jumps redirect it, flushing buffered and in-flight instructions.

## Interface
- RESET_PC, 32'h00003000, fetch address loaded on reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2; also the maximum outstanding requests

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  new fetch target
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address requested (current fetch_pc)
- imem_rsp_valid  in  1  one response word, in request order; no backpressure
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  FIFO head valid
- if_ready  in  1  core consumes head
- if_instr  out  32  head instruction
- if_pc  out  32  PC of head instruction
- if_fault  out  1  misaligned-target fault marker (see Configuration)

## Operation
- State: fetch_pc, FIFO (instr+pc per entry, rd/wr pointers, count), outstanding count, drop count, FSM {RUN, FAULT}.
- imem_req_valid = (state==RUN) && (count + outstanding < FIFO_DEPTH). Guarantees a FIFO slot for every response.
- Request handshake (valid && ready): outstanding+1, fetch_pc += 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
- Response: outstanding-1. If drop > 0: discard, drop-1. Else write {imem_rsp_data, pc tag} to FIFO; pc tag is a response-PC register advanced by 4 per kept response, loaded with fetch target on reset/redirect.
- Consume: if_valid && if_ready pops head.
- Redirect (priority over everything): FIFO flushed (count=0, pointers reset), fetch_pc = redirect_pc, response-PC = redirect_pc, drop = outstanding after this cycle's request/response updates (a request accepted in the redirect cycle is stale; a response arriving in it is discarded). Pop in the same cycle is ignored.
- Simultaneous write and pop: count unchanged. Outputs read FIFO head combinationally from registered storage.

## Timing
- Reset: if_valid=0, if_fault=0, imem_req_valid=0, if_instr=0, if_pc=0, fetch_pc=RESET_PC, counts 0, state RUN.
- First request: first cycle after reset deasserts, address RESET_PC.
- Response at cycle N -> if_valid at N+1 (FIFO was empty).
- Redirect at cycle N -> if_valid=0 at N+1; request to redirect_pc offered at N+1 if capacity allows.
- Full throughput: one instruction/cycle with single-cycle memory and if_ready held high.
- if_instr/if_pc stable while if_valid && !if_ready.

## Configuration
- IFETCH_MISALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=0 enters FAULT: flush as normal, no requests, if_valid=1, if_fault=1, if_instr=32'h00000013, if_pc=redirect_pc; after pop, if_valid=0 and stalls until next redirect (aligned -> RUN, misaligned -> FAULT again). Reset -> RUN.
- Undefined: no check, FAULT unreachable, if_fault tied 0, redirect_pc[1:0] forced to 0.

## Test plan
- Reset, 1-cycle memory, if_ready=1 -> requests 0x3000,0x3004,0x3008…; if_pc sequence 0x3000,0x3004… one per cycle starting 2 cycles after reset release.
- if_ready=0, 1-cycle memory -> exactly 4 requests, if_valid=1, imem_req_valid=0 thereafter, head pc=0x3000 stable.
- 3-cycle memory latency, redirect to 0x3100 with 2 in flight -> both stale responses dropped; first delivered if_pc=0x3100.
- Redirect in same cycle as request accept and response arrival -> neither delivered; next delivered pc=redirect_pc.
- fetch_pc=0xFFFFFFFC -> next request address 0x00000000.
- With IFETCH_MISALIGN_CHK_EN, redirect to 0x3102 -> if_fault=1, if_instr=0x00000013, if_pc=0x3102, no requests; redirect 0x3200 -> normal fetch from 0x3200.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order word requests, buffers responses in a small FIFO and
// hands {instr, pc} to the core. Optional misaligned-redirect check: IFETCH_MISALIGN_CHK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {RUN, FAULT} state_t;

  state_t             state, state_next;
  logic [31:0]        fetch_pc;
  logic [31:0]        rsp_pc;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, outstanding, drop, out_next;
  logic [CNT_W:0]     inflight;
  logic [31:0]        mem_instr [FIFO_DEPTH];
  logic [31:0]        mem_pc    [FIFO_DEPTH];
  logic [31:0]        redirect_target;
  logic               req_fire, rsp_take, rsp_keep, rsp_drop, fifo_pop;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic fault_valid;
  assign redirect_target = redirect_pc;
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = rsp_take && (drop != '0);
  assign rsp_keep = rsp_take && (drop == '0) && !redirect_valid;
  assign fifo_pop = if_valid && if_ready && (state == RUN) && !redirect_valid;
  assign out_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_next = state;
    if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_CHK_EN
      state_next = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
`else
      state_next = RUN;
`endif
    end
  end

  // Output logic; head is read combinationally from registered storage.
  always_comb begin
    imem_req_valid = !reset && (state == RUN) && (inflight < (CNT_W+1)'(FIFO_DEPTH));
    imem_req_addr  = fetch_pc;
    if_valid       = 1'b0;
    if_instr       = '0;
    if_pc          = '0;
    if_fault       = 1'b0;
    if (!reset && (state == RUN) && (count != '0)) begin
      if_valid = 1'b1;
      if_instr = mem_instr[rd_ptr];
      if_pc    = mem_pc[rd_ptr];
    end
`ifdef IFETCH_MISALIGN_CHK_EN
    // fetch_pc holds the faulting target: no requests advance it while in FAULT.
    else if (!reset && (state == FAULT) && fault_valid) begin
      if_valid = 1'b1;
      if_fault = 1'b1;
      if_instr = NOP_INSTR;
      if_pc    = fetch_pc;
    end
`endif
  end

  // Pointers, counters and PCs
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        drop     <= out_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_drop) drop <= drop - CNT_W'(1);
        if (rsp_keep) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({rsp_keep, fifo_pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      mem_instr[wr_ptr] <= imem_rsp_data;
      mem_pc[wr_ptr]    <= rsp_pc;
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (reset)
      fault_valid <= 1'b0;
    else if (redirect_valid)
      fault_valid <= (redirect_pc[1:0] != 2'b00);
    else if ((state == FAULT) && fault_valid && if_ready)
      fault_valid <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios push expected deliveries,
// a monitor pops and compares each accepted {instr, pc, fault}. Memory returns ~addr.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t  exp_q [$];
  pend_t pend  [$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    mem_lat  = 1;
  int    req_cnt  = 0;
  int    cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = base + 32'(4 * i);
      e.instr = ~e.pc;
      e.fault = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      next_cycle();
      if (exp_q.size() == 0) break;
    end
    if_ready = 1'b0;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Leaves the bench at the start of the first cycle after reset release (c0).
  task automatic do_reset(input int lat);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = lat;
    repeat (3) next_cycle();
    sample();
    check("rst_if_valid",  if_valid,       1'b0);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_if_fault",  if_fault,       1'b0);
    check("rst_if_instr",  if_instr,       32'h0);
    check("rst_if_pc",     if_pc,          32'h0);
    next_cycle();
    reset = 1'b0;
  endtask

  // Memory model: in-order responses after mem_lat cycles, data = ~addr.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~pend[0].addr;
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      @(negedge clk);
      if (reset) begin
        pend.delete();
        req_cnt = 0;
      end else if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc + mem_lat});
        req_cnt++;
      end
    end
  end

  // Monitor: compare every accepted delivery against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_delivery: got pc %h instr %h expected none", if_pc, if_instr);
      end else begin
        mon_e = exp_q.pop_front();
        check("dlv_pc",    if_pc,    mon_e.pc);
        check("dlv_instr", if_instr, mon_e.instr);
        check("dlv_fault", if_fault, mon_e.fault);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Streaming with 1-cycle memory: first if_valid two cycles after release.
    do_reset(1);
    if_ready = 1'b1;
    push_seq(32'h0000_3000, 8);
    sample();
    check("s1_req_valid_c0", imem_req_valid, 1'b1);
    check("s1_req_addr_c0",  imem_req_addr,  32'h0000_3000);
    check("s1_if_valid_c0",  if_valid,       1'b0);
    next_cycle();
    sample();
    check("s1_req_addr_c1",  imem_req_addr,  32'h0000_3004);
    check("s1_if_valid_c1",  if_valid,       1'b0);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      sample();
      check("s1_throughput", if_valid, 1'b1);
    end
    wait_drain("s1");

    // Backpressure: exactly FIFO_DEPTH requests, then stall with a stable head.
    do_reset(1);
    repeat (10) next_cycle();
    sample();
    check("s2_req_cnt",    32'(req_cnt),   32'd4);
    check("s2_req_valid",  imem_req_valid, 1'b0);
    check("s2_if_valid",   if_valid,       1'b1);
    check("s2_head_pc",    if_pc,          32'h0000_3000);
    check("s2_head_instr", if_instr,       ~32'h0000_3000);
    repeat (3) next_cycle();
    sample();
    check("s2_head_stable", if_pc, 32'h0000_3000);
    push_seq(32'h0000_3000, 6);
    next_cycle();
    if_ready = 1'b1;
    wait_drain("s2");

    // 3-cycle memory, redirect to 0x3100 with two requests in flight.
    do_reset(3);
    if_ready = 1'b1;
    push_seq(32'h0000_3100, 4);
    next_cycle();
    next_cycle();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3100;
    next_cycle();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    sample();
    check("s3_if_valid_n1",  if_valid,       1'b0);
    check("s3_req_valid_n1", imem_req_valid, 1'b1);
    check("s3_req_addr_n1",  imem_req_addr,  32'h0000_3100);
    wait_drain("s3");

    // Redirect coinciding with a request accept and a response arrival.
    do_reset(1);
    if_ready = 1'b1;
    push_seq(32'h0000_3200, 3);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3200;
    sample();
    check("s4_req_valid_c1", imem_req_valid, 1'b1);
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    check("s4_if_valid_n1", if_valid,      1'b0);
    check("s4_req_addr_n1", imem_req_addr, 32'h0000_3200);
    wait_drain("s4");

    // Fetch address wraps from 0xFFFFFFFC to 0.
    do_reset(1);
    if_ready = 1'b1;
    push_seq(32'hFFFF_FFF8, 4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    check("s5_addr_fff8", imem_req_addr, 32'hFFFF_FFF8);
    next_cycle();
    sample();
    check("s5_addr_fffc", imem_req_addr, 32'hFFFF_FFFC);
    next_cycle();
    sample();
    check("s5_addr_wrap", imem_req_addr, 32'h0000_0000);
    wait_drain("s5");

`ifdef IFETCH_MISALIGN_CHK_EN
    // Misaligned redirect enters FAULT and presents a single NOP marker.
    do_reset(1);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3102;
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    check("s6_if_valid",  if_valid,       1'b1);
    check("s6_if_fault",  if_fault,       1'b1);
    check("s6_if_instr",  if_instr,       32'h0000_0013);
    check("s6_if_pc",     if_pc,          32'h0000_3102);
    check("s6_req_valid", imem_req_valid, 1'b0);
    repeat (4) next_cycle();
    sample();
    check("s6_no_new_reqs", 32'(req_cnt), 32'd2);
    exp_q.push_back('{32'h0000_3102, 32'h0000_0013, 1'b1});
    next_cycle();
    if_ready = 1'b1;
    wait_drain("s6_fault");
    next_cycle();
    sample();
    check("s6_stall_valid", if_valid,       1'b0);
    check("s6_stall_req",   imem_req_valid, 1'b0);
    push_seq(32'h0000_3200, 3);
    next_cycle();
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3200;
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    check("s6_resume_addr", imem_req_addr, 32'h0000_3200);
    wait_drain("s6_resume");
`else
    // Without the check, low target bits are ignored.
    do_reset(1);
    if_ready = 1'b1;
    push_seq(32'h0000_3100, 3);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3102;
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    check("s6_if_fault",   if_fault,      1'b0);
    check("s6_req_addr",   imem_req_addr, 32'h0000_3100);
    wait_drain("s6");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
